// File: rtl/spi_pkg.sv
// Shared encodings for the SPI shift engine: FSM states, mode bit positions, default widths.
package spi_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int CNT_W_DEF  = 5;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  // mode = {CPOL, CPHA}
  localparam int CPOL_BIT = 1;
  localparam int CPHA_BIT = 0;
endpackage

// File: rtl/spi_cs_ctrl.sv
// Chip-select decode for four active-low selects: auto (follows the frame) or manual level.
// Purely combinational, no latency, no backpressure.
module spi_cs_ctrl (
  input  logic       i_busy,
  input  logic [1:0] i_sel,
  input  logic [3:0] i_cs_auto,
  input  logic [3:0] i_cs_enable,
  output logic [3:0] o_cs_n
);
  for (genvar n = 0; n < 4; n++) begin : g_cs
    assign o_cs_n[n] = ~(i_cs_auto[n] ? (i_busy && (i_sel == 2'(n))) : i_cs_enable[n]);
  end
endmodule

// File: rtl/spi_shift_engine.sv
// SPI shift stage: pops one TX word per frame, shifts MSB-first on baud-tick SCLK, pushes the RX word.
// Stalls while TX empty; drops the word when RX full. Optional SPI_LOOPBACK_EN adds i_loopback.
module spi_shift_engine
  import spi_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic              i_baud_tick,
  input  logic [CNT_W-1:0]  i_word_size,
  input  logic [1:0]        i_mode,
  input  logic [1:0]        i_cs_select,
  input  logic [3:0]        i_cs_auto,
  input  logic [3:0]        i_cs_enable,
  input  logic              i_tx_empty,
  input  logic [DATA_W-1:0] i_tx_data,
  output logic              o_tx_pop,
  input  logic              i_rx_full,
  output logic [DATA_W-1:0] o_rx_data,
  output logic              o_rx_push,
  output logic              o_rx_drop,
  output logic              o_busy,
  output logic              o_spi_clk,
  output logic              o_spi_tx,
  input  logic              i_spi_rx,
`ifdef SPI_LOOPBACK_EN
  input  logic              i_loopback,
`endif
  output logic              o_spi_cs0,
  output logic              o_spi_cs1,
  output logic              o_spi_cs2,
  output logic              o_spi_cs3
);
  logic [1:0]        r_state;
  logic [DATA_W-1:0] r_tx_word;
  logic [DATA_W-1:0] r_rx_sh;
  logic [DATA_W-1:0] r_rx_data;
  logic [CNT_W-1:0]  r_ws;
  logic [CNT_W-1:0]  r_idx;
  logic [1:0]        r_mode;
  logic [1:0]        r_sel;
  logic              r_half;
  logic              r_clk;
  logic              r_mosi;
  logic              r_push;
  logic              r_drop;
  logic              r_cs_gap;

  logic              w_start;
  logic              w_miso;
  logic              w_cpha;
  logic              w_cpol;
  logic              w_last;
  logic [CNT_W-1:0]  w_idx_m1;
  logic [DATA_W-1:0] w_rx_next;
  logic [3:0]        w_cs_n;

  // r_cs_gap keeps a new frame from starting until one baud tick has passed with CS released
  assign w_start   = (r_state == ST_IDLE) && i_enable && !i_tx_empty && !r_cs_gap;
  assign w_cpha    = r_mode[CPHA_BIT];
  assign w_cpol    = r_mode[CPOL_BIT];
  assign w_last    = (r_idx == '0);
  assign w_idx_m1  = r_idx - 1'b1;
  assign w_rx_next = {r_rx_sh[DATA_W-2:0], w_miso};

`ifdef SPI_LOOPBACK_EN
  assign w_miso = i_loopback ? r_mosi : i_spi_rx;
`else
  assign w_miso = i_spi_rx;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_tx_word <= '0;
      r_rx_sh   <= '0;
      r_rx_data <= '0;
      r_ws      <= '0;
      r_idx     <= '0;
      r_mode    <= '0;
      r_sel     <= '0;
      r_half    <= 1'b0;
      r_clk     <= 1'b0;
      r_mosi    <= 1'b0;
      r_push    <= 1'b0;
      r_drop    <= 1'b0;
      r_cs_gap  <= 1'b0;
    end else begin
      r_push <= 1'b0;
      r_drop <= 1'b0;
      if (i_baud_tick) r_cs_gap <= 1'b0;
      if (!i_enable && (r_state != ST_IDLE)) begin
        r_state  <= ST_IDLE;
        r_mosi   <= 1'b0;
        r_clk    <= w_cpol;
        r_cs_gap <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_clk  <= i_mode[CPOL_BIT];
            r_mosi <= 1'b0;
            if (w_start) begin
              r_tx_word <= i_tx_data;
              r_ws      <= i_word_size;
              r_mode    <= i_mode;
              r_sel     <= i_cs_select;
              r_rx_sh   <= '0;
              r_mosi    <= i_mode[CPHA_BIT] ? 1'b0 : i_tx_data[i_word_size];
              r_state   <= ST_SETUP;
            end
          end
          ST_SETUP: begin
            if (i_baud_tick) begin
              r_state <= ST_SHIFT;
              r_idx   <= r_ws;
              r_half  <= 1'b0;
            end
          end
          ST_SHIFT: begin
            if (i_baud_tick) begin
              r_clk  <= ~r_clk;
              r_half <= ~r_half;
              if (!r_half) begin
                if (!w_cpha) r_rx_sh <= w_rx_next;
                else         r_mosi  <= r_tx_word[r_idx];
              end else begin
                if (w_cpha) r_rx_sh <= w_rx_next;
                if (w_last) begin
                  r_state <= ST_HOLD;
                  r_clk   <= w_cpol;
                end else begin
                  r_idx <= w_idx_m1;
                  if (!w_cpha) r_mosi <= r_tx_word[w_idx_m1];
                end
              end
            end
          end
          default: begin
            if (i_baud_tick) begin
              r_push   <= !i_rx_full;
              r_drop   <= i_rx_full;
              if (!i_rx_full) r_rx_data <= r_rx_sh;
              r_state  <= ST_IDLE;
              r_cs_gap <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  spi_cs_ctrl u_cs (
    .i_busy      (o_busy),
    .i_sel       (r_sel),
    .i_cs_auto   (i_cs_auto),
    .i_cs_enable (i_cs_enable),
    .o_cs_n      (w_cs_n)
  );

  assign o_tx_pop  = w_start;
  assign o_busy    = (r_state != ST_IDLE);
  assign o_rx_data = r_rx_data;
  assign o_rx_push = r_push;
  assign o_rx_drop = r_drop;
  assign o_spi_clk = r_clk;
  assign o_spi_tx  = r_mosi;
  assign o_spi_cs0 = w_cs_n[0];
  assign o_spi_cs1 = w_cs_n[1];
  assign o_spi_cs2 = w_cs_n[2];
  assign o_spi_cs3 = w_cs_n[3];
endmodule
